matrix_deskew: RTL and testbench
================================

// Module: matrix_deskew
// PURPOSE
//  Reassembles an N x N matrix from a skewed anti-diagonal vector stream, one
//  vector per accepted beat. Lane i of beat s carries element [i][s-i].
//  Lanes outside the diagonal window carry 0. This is the same stream format
//  matrix_timer emits.
//  Sits at the output edge of the systolic array. It collects skewed results
//  back into row-major matrix form and hands them downstream with a
//  valid/ready handshake.
// PARAMETERS
//  N   32   matrix dimension, lanes per vector
//  W   16   element width in bits
//  SW  $clog2(2*N-1)   step counter width (derived, not overridden)
// PORTS
//  clk          in   1      clock, all logic on posedge
//  rst          in   1      synchronous reset, active-high
//  en           in   1      frame enable; low aborts and idles the block
//  in_valid     in   1      vector_in holds a valid beat
//  in_ready     out  1      block accepts a beat this cycle (COLLECT state)
//  vector_in    in   W x N  unpacked [0:N-1] of [W-1:0], skewed lane data
//  matrix_out   out  W x NxN  unpacked [0:N-1][0:N-1] of [W-1:0], assembled matrix
//  out_valid    out  1      matrix_out holds a complete frame
//  out_ready    in   1      downstream consumes the frame
//  busy         out  1      state != IDLE
//  err          out  1      sticky skew-violation flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst=1, dominates en)
//   - state=IDLE, step=0, out_valid=0, err=0, every matrix_out element=0.
//  States: IDLE, COLLECT, FULL. in_ready = (state==COLLECT), combinational.
//  IDLE
//   - en=1 -> COLLECT next cycle; no beat is captured in IDLE.
//  COLLECT: a beat is accepted when in_valid=1. For each lane i:
//   - if i<=step and step-i<N: matrix_out[i][step-i] <= vector_in[i].
//   - out-of-window lanes are never written.
//   - Compare in SW+1 bits; no wrap.
//   - step increments per accepted beat only; in_valid=0 cycles leave all
//     state unchanged (gaps allowed).
//   - Beat at step==2N-2 accepted -> next cycle: state=FULL, out_valid=1,
//     step=0.
//   - Latency: 2N-1 accepted beats; 63 for N=32. With back-to-back beats from
//     the first COLLECT cycle C, out_valid=1 at cycle C+63.
//  FULL
//   - out_valid held at 1; matrix_out frozen; in_ready=0 (beats not taken).
//   - out_ready=1 -> next cycle out_valid=0, state=COLLECT if en else IDLE.
//   - The first beat of the next frame is accepted no earlier than the cycle
//     after the handshake; there is no same-cycle bypass.
//  en=0 in any state (rst=0)
//   - next cycle state=IDLE, step=0, out_valid=0. Any held frame is dropped.
//   - matrix_out keeps its contents, including a partial frame; not cleared.
//   - err clears.
//  Simultaneous events
//   - en=0 with out_ready=1: en=0 wins.
//   - rst with anything: rst wins.
//  All outputs registered except in_ready and busy (decoded from state reg).
// CONFIGURATION
//  MATRIX_DESKEW_ZERO_CHECK_EN defined
//   - On each accepted beat, any out-of-window lane (i>step or step-i>=N) with
//     nonzero data sets err=1 next cycle.
//   - err is sticky until rst=1 or en=0.
//   - Data is still not written.
//  Undefined
//   - No check logic; err tied to 0.
// TESTING
//  1 rst=1 two cycles -> out_valid=0, in_ready=0, busy=0, all matrix_out=0.
//  2 N=32, M[i][j]=i*32+j; feed 63 skewed beats back-to-back from first
//    COLLECT cycle -> out_valid=1 exactly 63 cycles later, matrix_out==M.
//  3 Same frame, in_valid toggling 1/0 -> identical matrix_out, out_valid
//    after the 63rd accepted beat, never earlier.
//  4 Hold out_ready=0 for 10 cycles with in_valid=1 -> out_valid stays 1,
//    matrix_out unchanged, in_ready=0. Pulse out_ready -> out_valid=0;
//    next frame fills from step 0.
//  5 Drop en after 20 beats -> state IDLE, out_valid never rises. Raise en and
//    send a full frame of M'=~M -> matrix_out==M', out_valid=1.
//  6 Macro defined: lane 5 = 16'h0001 at step 2 -> err=1 next cycle, stays 1
//    until en=0. Macro undefined: same stimulus -> err=0.

Source files
------------

// File: rtl/matrix_deskew.sv
// matrix_deskew: rebuilds an N x N row-major matrix from a skewed anti-diagonal beat stream.
// Optional zero-check of out-of-window lanes is enabled by defining MATRIX_DESKEW_ZERO_CHECK_EN.
module matrix_deskew #(
   parameter  int N  = 32,
   parameter  int W  = 16,
   localparam int SW = $clog2(2*N-1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] vector_in  [0:N-1],
   output logic [W-1:0] matrix_out [0:N-1][0:N-1],
   output logic         out_valid,
   input  logic         out_ready,
   output logic         busy,
   output logic         err
);

   typedef enum logic [1:0] {IDLE, COLLECT, FULL} state_t;
   typedef logic [SW:0] stepx_t;

   state_t        state, state_nxt;
   logic [SW-1:0] step;
   logic          accept;
   logic          last_beat;

   assign accept    = (state == COLLECT) && in_valid;
   assign last_beat = (step == SW'(2*N-2));

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (!en) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    state_nxt = COLLECT;
            COLLECT: if (accept && last_beat) state_nxt = FULL;
            FULL:    if (out_ready) state_nxt = COLLECT;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      in_ready = (state == COLLECT);
      busy     = (state != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst || !en) begin
         step      <= '0;
         out_valid <= 1'b0;
      end else begin
         if (accept) step <= last_beat ? '0 : step + 1'b1;
         if (accept && last_beat)
            out_valid <= 1'b1;
         else if (state == FULL && out_ready)
            out_valid <= 1'b0;
      end
   end

   // Element [i][j] arrives on lane i at step i+j; the equality alone keeps writes inside the window.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
               matrix_out[i][j] <= '0;
      end else if (en && accept) begin
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
               if ({1'b0, step} == stepx_t'(i+j))
                  matrix_out[i][j] <= vector_in[i];
      end
   end

`ifdef MATRIX_DESKEW_ZERO_CHECK_EN
   function automatic logic in_window(input logic [SW-1:0] s, input int lane);
      stepx_t sx;
      sx = {1'b0, s};
      return (sx >= stepx_t'(lane)) && (sx <= stepx_t'(lane+N-1));
   endfunction

   logic stray;

   always_comb begin
      stray = 1'b0;
      for (int i = 0; i < N; i++)
         if (!in_window(step, i) && (vector_in[i] != '0)) stray = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst || !en)          err <= 1'b0;
      else if (accept && stray) err <= 1'b1;
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_deskew.sv
// Randomized self-checking bench for matrix_deskew against a beat-count reference model.
// Expected err follows MATRIX_DESKEW_ZERO_CHECK_EN as compiled.
module tb_matrix_deskew;
   localparam int N = 32;
   localparam int W = 16;
   localparam int B = 2*N-1;
`ifdef MATRIX_DESKEW_ZERO_CHECK_EN
   localparam bit ZC = 1'b1;
`else
   localparam bit ZC = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, en, in_valid, out_ready;
   logic [W-1:0] vector_in  [0:N-1];
   logic [W-1:0] matrix_out [0:N-1][0:N-1];
   logic         in_ready, out_valid, busy, err;

   matrix_deskew #(.N(N), .W(W)) dut (
      .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
      .vector_in(vector_in), .matrix_out(matrix_out), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy), .err(err)
   );

   int passed = 0;
   int total  = 0;

   task automatic check(input string tag, input logic [N*W-1:0] got, input logic [N*W-1:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Reference model: mode 0 idle, 1 collecting, 2 holding a full frame.
   int           mode, cnt;
   bit           m_ov, m_err, inject;
   logic [W-1:0] m_mat [0:N-1][0:N-1];
   logic [W-1:0] frame [0:N-1][0:N-1];

   task automatic drive_beat();
      for (int i = 0; i < N; i++) begin
         int j = cnt - i;
         vector_in[i] = (j >= 0 && j < N) ? frame[i][j] : '0;
      end
      if (inject && cnt == 2) vector_in[5] = 16'h0001;
   endtask

   task automatic model_step();
      if (rst) begin
         mode = 0; cnt = 0; m_ov = 0; m_err = 0;
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) m_mat[i][j] = '0;
      end else if (!en) begin
         mode = 0; cnt = 0; m_ov = 0; m_err = 0;
      end else if (mode == 0) begin
         mode = 1;
      end else if (mode == 1) begin
         if (in_valid) begin
            for (int i = 0; i < N; i++) begin
               int j = cnt - i;
               if (j >= 0 && j < N) m_mat[i][j] = vector_in[i];
               else if (ZC && vector_in[i] != '0) m_err = 1;
            end
            cnt++;
            if (cnt == B) begin
               mode = 2; m_ov = 1; cnt = 0;
            end
         end
      end else if (out_ready) begin
         m_ov = 0; mode = 1;
      end
   endtask

   task automatic tick(input logic v, input logic ordy);
      in_valid  = v;
      out_ready = ordy;
      drive_beat();
      model_step();
      @(posedge clk);
      @(negedge clk);
      check("out_valid", out_valid, m_ov);
      check("in_ready", in_ready, mode == 1);
      check("busy", busy, mode != 0);
      check("err", err, m_err);
   endtask

   task automatic check_matrix(input string tag);
      for (int r = 0; r < N; r++) begin
         logic [N*W-1:0] g, e;
         for (int c = 0; c < N; c++) begin
            g[c*W +: W] = matrix_out[r][c];
            e[c*W +: W] = m_mat[r][c];
         end
         check($sformatf("%s_r%0d", tag, r), g, e);
      end
   endtask

   task automatic check_frame(input string tag);
      for (int r = 0; r < N; r++) begin
         logic [N*W-1:0] g, e;
         for (int c = 0; c < N; c++) begin
            g[c*W +: W] = matrix_out[r][c];
            e[c*W +: W] = frame[r][c];
         end
         check($sformatf("%s_r%0d", tag, r), g, e);
      end
   endtask

   task automatic random_frame();
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) frame[i][j] = W'($urandom);
   endtask

   // Streams beats until out_valid, with in_valid pattern chosen by gap_mode.
   task automatic run_frame(input int gap_mode, output int cycles);
      cycles = 0;
      while (!out_valid && cycles < 400) begin
         logic v;
         case (gap_mode)
            0:       v = 1'b1;
            1:       v = (cycles % 2 == 0);
            default: v = 1'($urandom_range(0, 1));
         endcase
         tick(v, 1'b0);
         cycles++;
      end
      check("frame_done", {31'd0, out_valid}, 32'd1);
   endtask

   initial begin
      int lat;
      rst = 1'b1; en = 1'b0; in_valid = 1'b0; out_ready = 1'b0; inject = 1'b0;
      cnt = 0; mode = 0;
      for (int i = 0; i < N; i++) vector_in[i] = '0;
      random_frame();
      tick(0, 0);
      tick(0, 0);
      check_matrix("reset");
      rst = 1'b0;

      // Reference frame M[i][j] = i*32+j, back-to-back beats.
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) frame[i][j] = W'(i*32 + j);
      en = 1'b1;
      tick(0, 0);
      run_frame(0, lat);
      check("latency", lat, B);
      check_frame("frame_m");

      // Backpressure: frame held while beats are offered.
      for (int k = 0; k < 10; k++) tick(1, 0);
      check_frame("held");
      tick(0, 1);

      // Same frame with toggling in_valid, then random data with random gaps.
      run_frame(1, lat);
      check("latency_gapped", lat, 2*B-1);
      check_frame("gapped");
      tick(0, 1);
      random_frame();
      run_frame(2, lat);
      check_frame("random_gaps");
      tick(1, 1);

      // Abort after 20 beats; partial frame stays visible.
      random_frame();
      for (int k = 0; k < 20; k++) tick(1, 0);
      en = 1'b0;
      for (int k = 0; k < 4; k++) tick(1, 0);
      check_matrix("partial");
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) frame[i][j] = ~frame[i][j];
      en = 1'b1;
      tick(0, 0);
      run_frame(0, lat);
      check("latency_inv", lat, B);
      check_frame("inverted");

      // en=0 wins over out_ready while a frame is held.
      en = 1'b0;
      tick(0, 1);
      tick(0, 0);
      check_matrix("dropped");

      // Stray nonzero lane outside the diagonal window.
      en = 1'b1;
      inject = 1'b1;
      random_frame();
      tick(0, 0);
      for (int k = 0; k < 8; k++) tick(1, 0);
      for (int k = 0; k < 3; k++) tick(0, 0);
      inject = 1'b0;
      en = 1'b0;
      tick(0, 0);
      check_matrix("after_err");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
